// File: rtl/key_debounce_pkg.sv
// Shared definitions for the push-button debounce front-end:
// per-channel FSM state encodings and the default qualification time.
package key_debounce_pkg;

    // 20 ms at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESS_CHK = 2'd1,
        ST_HELD      = 2'd2,
        ST_REL_CHK   = 2'd3
    } key_state_e;

    // True when the debounced level is "held" (active-low output = 0).
    function automatic logic is_held(input key_state_e st);
        return (st == ST_HELD) || (st == ST_REL_CHK);
    endfunction

endpackage

// File: rtl/key_debounce_if.sv
// Key bus between the board buttons and the LED selector stage.
// master: the button side (drives raw levels, sees the results).
// slave : the debounce block.
interface key_debounce_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_raw;    // raw levels, 0 = pressed, async to clk
    logic [NUM_KEYS-1:0] key_pulse;  // 1-cycle active-low press pulse
    logic [NUM_KEYS-1:0] key_level;  // debounced level, 0 = held

    modport master (
        output key_raw,
        input  key_pulse,
        input  key_level
    );

    modport slave (
        input  key_raw,
        output key_pulse,
        output key_level
    );
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, 4-state debounce FSM with a
// qualification counter, and registered pulse/level outputs.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rstn_signal,
    input  logic i_key_raw,
    output logic o_key_pulse,
    output logic o_key_level
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;      // synchronised key level (ks)
    key_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;
    logic             r_level;

    key_state_e       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_pulse_next;
    logic             w_level_next;
    logic             w_cnt_done;

    // Synchroniser: raw pin goes straight into flop 1; idles at "released".
    // The reset release is expected to be synchronised upstream; assertion
    // is taken asynchronously here.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State register and qualification counter.
    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_cnt_done = (r_cnt == CNT_LAST);

    // Next-state and counter logic; counter cleared on every state entry,
    // so the compare caps it and it never wraps.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned,
        // which would otherwise infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (!r_sync2) begin
                    w_state_next = ST_PRESS_CHK;
                    w_cnt_next   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (r_sync2) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else if (w_cnt_done) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (r_sync2) begin
                    w_state_next = ST_REL_CHK;
                    w_cnt_next   = '0;
                end
            end
            ST_REL_CHK: begin
                if (!r_sync2) begin
                    w_state_next = ST_HELD;
                    w_cnt_next   = '0;
                end else if (w_cnt_done) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output decode: pulse on the qualifying PRESS_CHK -> HELD transition
    // only; level follows the state being entered.
    always_comb begin
        w_pulse_next = !((r_state == ST_PRESS_CHK) && !r_sync2 && w_cnt_done);
        w_level_next = !is_held(w_state_next);
    end

    // Output registers, idle high.
    always_ff @(posedge clk or negedge rstn_signal) begin
        if (!rstn_signal) begin
            r_pulse <= 1'b1;
            r_level <= 1'b1;
        end else begin
            r_pulse <= w_pulse_next;
            r_level <= w_level_next;
        end
    end

    assign o_key_pulse = r_pulse;
    assign o_key_level = r_level;

endmodule

// File: rtl/key_debounce.sv
// Push-button front-end: NUM_KEYS independent debounce channels.
// Simultaneous presses pulse independently; priority is resolved downstream.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rstn_signal,
    key_debounce_if.slave bus
);

    logic [NUM_KEYS-1:0] w_key_pulse;
    logic [NUM_KEYS-1:0] w_key_level;

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .clk         (clk),
            .rstn_signal (rstn_signal),
            .i_key_raw   (bus.key_raw[g]),
            .o_key_pulse (w_key_pulse[g]),
            .o_key_level (w_key_level[g])
        );
    end

    assign bus.key_pulse = w_key_pulse;
    assign bus.key_level = w_key_level;

endmodule
